mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage; consumes its MEM_* pipeline registers.
- Issues load/store requests to the data-memory port over a req/ack handshake.
- Aligns store data and generates byte enables; extracts and sign/zero-extends load data.
- Registers the result into the WB_* pipeline latch; stalls upstream while an access is outstanding; forwards branch redirect to fetch.

Parameters:
- DMEM_TIMEOUT, 256, cycles waited for DMEM_ACK before the access is abandoned with a bus error.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- MEM_V  in  1  valid from execute.
- MEM_IR  in  32  instruction.
- MEM_Cst  in  17  control store word, passed through.
- MEM_RES  in  64  ALU result; store data for stores.
- MEM_Address  in  64  effective load/store address.
- MEM_NPC  in  64  next PC, passed through.
- MEM_PC_MUX  in  1  branch-taken flag.
- MEM_Target_Address  in  64  branch target.
- DMEM_REQ  out  1  memory request, registered.
- DMEM_WE  out  1  1 = store.
- DMEM_ADDR  out  64  MEM_Address with [2:0] = 0.
- DMEM_WDATA  out  64  store data, lane-shifted.
- DMEM_BE  out  8  byte enables.
- DMEM_ACK  in  1  access complete.
- DMEM_RDATA  in  64  read doubleword, valid with ACK.
- MEM_STALL  out  1  upstream holds all MEM_* stable while high.
- MEM_FE_BR_TAKEN  out  1  MEM_V & MEM_PC_MUX, combinational.
- MEM_FE_TARGET  out  64  MEM_Target_Address, combinational.
- MEM_DR  out  5  MEM_IR[11:7].
- WB_V  out  1  writeback valid.
- WB_RES  out  64  writeback data.
- WB_IR  out  32  instruction, registered.
- WB_Cst  out  17  control store word, registered.
- WB_NPC  out  64  next PC, registered.
- WB_EXC  out  1  bus error / misalign flag.

Behaviour:
- Op class from MEM_IR[6:2]:
  - 00000 = load.
  - 01000 = store.
  - anything else = non-memory.
- size/sign from MEM_IR[14:12]:
  - Loads: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
  - Stores: 000 SB, 001 SH, 010 SW, 011 SD.
- off = MEM_Address[2:0].
- FSM states: IDLE, ACCESS.
- IDLE:
  - MEM_V=0: WB_V<=0.
  - MEM_V=1, non-memory op: 1-cycle pass-through. WB_V<=1, WB_RES<=MEM_RES, WB_EXC<=0; IR/Cst/NPC latched.
  - MEM_V=1, load/store:
    - MEM_STALL=1 combinationally; WB_V<=0.
    - Next edge: enter ACCESS and register DMEM_REQ=1, DMEM_WE, DMEM_ADDR, DMEM_BE, DMEM_WDATA.
    - Store lane alignment: DMEM_BE = size_mask << off, with size_mask = 01/03/0F/FF. DMEM_WDATA = MEM_RES << (8*off).
    - Loads: DMEM_BE = size_mask << off; DMEM_WDATA = 0.
    - Timeout counter cleared.
- ACCESS:
  - DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_BE, DMEM_WDATA held stable until DMEM_ACK.
  - MEM_STALL = ~DMEM_ACK.
  - Counter increments each cycle without ACK.
  - On DMEM_ACK:
    - DMEM_REQ<=0 and return to IDLE.
    - WB_V<=1.
    - Load: WB_RES<=ext(DMEM_RDATA >> 8*off), sign- or zero-extended to 64 bits.
    - Store: WB_RES<=MEM_RES.
    - WB_EXC<=0.
  - Counter reaches DMEM_TIMEOUT-1 without ACK: DMEM_REQ<=0, WB_V<=1, WB_RES<=0, WB_EXC<=1, return to IDLE.
  - ACK on the same cycle as timeout: ACK wins.
- Load-use latency: 2 cycles minimum (IDLE edge + ACK in first ACCESS cycle); non-memory ops take 1 cycle.
- Misaligned without feature: bytes beyond lane 7 are truncated (BE and data shifts discard overflow bits).
- DMEM_ACK in IDLE is ignored.
- Reset (RESET_N low, any time including mid-ACCESS):
  - State = IDLE.
  - DMEM_REQ=0, DMEM_WE=0, DMEM_BE=0, DMEM_ADDR=0, DMEM_WDATA=0.
  - WB_V=0, WB_EXC=0, WB_RES=0, WB_IR=0, WB_Cst=0, WB_NPC=0.
  - Counter=0.
  - A late ACK after reset release is ignored.

Optional Feature:
- MISALIGN_TRAP_EN
  - Defined: a load/store with off not a multiple of the access size issues no request and stays in IDLE. Result is 1-cycle: WB_V<=1, WB_EXC<=1, WB_RES<=MEM_Address (faulting address). MEM_STALL stays 0.
  - Undefined: truncation behaviour as above; WB_EXC only signals timeout.

Test Plan:
- ADD pass-through: MEM_V=1, IR opcode 0110011, MEM_RES=0x1234 -> next edge WB_V=1, WB_RES=0x1234, MEM_STALL never high, DMEM_REQ stays 0.
- LB, ACK on first ACCESS cycle: Address=0x1003, RDATA=0x00000000_80000000 -> DMEM_ADDR=0x1000, BE=0x08; WB_RES=0xFFFFFFFFFFFFFF80 two edges after presentation. LBU with the same data gives 0x80.
- SH with 3-cycle ACK delay: Address=0x2006, MEM_RES=0xBEEF -> BE=0xC0, WDATA=0xBEEF000000000000; MEM_STALL high 4 cycles; WB_V one pulse.
- Timeout with DMEM_TIMEOUT=4 and no ACK -> REQ drops after 4 ACCESS cycles; WB_V=1, WB_EXC=1, WB_RES=0.
- RESET_N asserted mid-ACCESS, then ACK pulsed after release -> REQ=0 immediately (asynchronous); WB_V stays 0.
- With MISALIGN_TRAP_EN, LW at 0x3002 -> no REQ; next edge WB_V=1, WB_EXC=1, WB_RES=0x3002.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: issues DMEM requests, aligns store lanes and extends load data into the WB latch.
// Build option MISALIGN_TRAP_EN: misaligned accesses trap in one cycle instead of issuing truncated requests.
module mem_stage #(
    parameter int DMEM_TIMEOUT = 256
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        MEM_V,
    input  logic [31:0] MEM_IR,
    input  logic [16:0] MEM_Cst,
    input  logic [63:0] MEM_RES,
    input  logic [63:0] MEM_Address,
    input  logic [63:0] MEM_NPC,
    input  logic        MEM_PC_MUX,
    input  logic [63:0] MEM_Target_Address,
    output logic        DMEM_REQ,
    output logic        DMEM_WE,
    output logic [63:0] DMEM_ADDR,
    output logic [63:0] DMEM_WDATA,
    output logic [7:0]  DMEM_BE,
    input  logic        DMEM_ACK,
    input  logic [63:0] DMEM_RDATA,
    output logic        MEM_STALL,
    output logic        MEM_FE_BR_TAKEN,
    output logic [63:0] MEM_FE_TARGET,
    output logic [4:0]  MEM_DR,
    output logic        WB_V,
    output logic [63:0] WB_RES,
    output logic [31:0] WB_IR,
    output logic [16:0] WB_Cst,
    output logic [63:0] WB_NPC,
    output logic        WB_EXC
);
    localparam int CW = $clog2(DMEM_TIMEOUT) + 1;

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_off;
    logic [2:0]    r_f3;
    logic          r_load;

    logic [4:0]  w_opc;
    logic [2:0]  w_f3;
    logic [2:0]  w_off;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_mem;
    logic [7:0]  w_size_mask;
    logic [7:0]  w_be;
    logic [63:0] w_wdata;
    logic        w_trap;
    logic [63:0] w_rsh;
    logic [63:0] w_load;

    assign w_opc      = MEM_IR[6:2];
    assign w_f3       = MEM_IR[14:12];
    assign w_off      = MEM_Address[2:0];
    assign w_is_load  = (w_opc == 5'b00000);
    assign w_is_store = (w_opc == 5'b01000);
    assign w_is_mem   = w_is_load | w_is_store;

    always_comb begin
        w_size_mask = 8'h01;
        case (w_f3[1:0])
            2'b00: w_size_mask = 8'h01;
            2'b01: w_size_mask = 8'h03;
            2'b10: w_size_mask = 8'h0F;
            2'b11: w_size_mask = 8'hFF;
        endcase
    end

    // Lanes shifted past byte 7 fall off the top; this is the intended truncation.
    assign w_be    = w_size_mask << w_off;
    assign w_wdata = MEM_RES << {w_off, 3'b000};

`ifdef MISALIGN_TRAP_EN
    logic [2:0] w_align_mask;
    assign w_align_mask = {w_f3[1] & w_f3[0], w_f3[1], |w_f3[1:0]};
    assign w_trap       = MEM_V & w_is_mem & (|(w_off & w_align_mask));
`else
    assign w_trap = 1'b0;
`endif

    assign w_rsh = DMEM_RDATA >> {r_off, 3'b000};

    always_comb begin
        w_load = w_rsh;
        case (r_f3)
            3'b000:  w_load = {{56{w_rsh[7]}},  w_rsh[7:0]};
            3'b001:  w_load = {{48{w_rsh[15]}}, w_rsh[15:0]};
            3'b010:  w_load = {{32{w_rsh[31]}}, w_rsh[31:0]};
            3'b100:  w_load = {56'd0, w_rsh[7:0]};
            3'b101:  w_load = {48'd0, w_rsh[15:0]};
            3'b110:  w_load = {32'd0, w_rsh[31:0]};
            default: w_load = w_rsh;
        endcase
    end

    assign MEM_STALL       = (r_state == S_IDLE) ? (MEM_V & w_is_mem & ~w_trap) : ~DMEM_ACK;
    assign MEM_FE_BR_TAKEN = MEM_V & MEM_PC_MUX;
    assign MEM_FE_TARGET   = MEM_Target_Address;
    assign MEM_DR          = MEM_IR[11:7];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_off      <= '0;
            r_f3       <= '0;
            r_load     <= 1'b0;
            DMEM_REQ   <= 1'b0;
            DMEM_WE    <= 1'b0;
            DMEM_ADDR  <= '0;
            DMEM_WDATA <= '0;
            DMEM_BE    <= '0;
            WB_V       <= 1'b0;
            WB_RES     <= '0;
            WB_IR      <= '0;
            WB_Cst     <= '0;
            WB_NPC     <= '0;
            WB_EXC     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!MEM_V) begin
                        WB_V <= 1'b0;
                    end else if (!w_is_mem || w_trap) begin
                        WB_V   <= 1'b1;
                        WB_RES <= w_trap ? MEM_Address : MEM_RES;
                        WB_EXC <= w_trap;
                        WB_IR  <= MEM_IR;
                        WB_Cst <= MEM_Cst;
                        WB_NPC <= MEM_NPC;
                    end else begin
                        WB_V       <= 1'b0;
                        r_state    <= S_ACCESS;
                        r_cnt      <= '0;
                        r_off      <= w_off;
                        r_f3       <= w_f3;
                        r_load     <= w_is_load;
                        DMEM_REQ   <= 1'b1;
                        DMEM_WE    <= w_is_store;
                        DMEM_ADDR  <= {MEM_Address[63:3], 3'b000};
                        DMEM_BE    <= w_be;
                        DMEM_WDATA <= w_is_store ? w_wdata : 64'd0;
                    end
                end
                S_ACCESS: begin
                    // MEM_* are held by the stall, so the WB latch can sample them on completion.
                    if (DMEM_ACK || (r_cnt == CW'(DMEM_TIMEOUT - 1))) begin
                        r_state  <= S_IDLE;
                        DMEM_REQ <= 1'b0;
                        WB_V     <= 1'b1;
                        WB_EXC   <= ~DMEM_ACK;
                        WB_RES   <= !DMEM_ACK ? 64'd0 : (r_load ? w_load : MEM_RES);
                        WB_IR    <= MEM_IR;
                        WB_Cst   <= MEM_Cst;
                        WB_NPC   <= MEM_NPC;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus random ops against a byte-level model.
module tb_mem_stage;
    logic        CLK;
    logic        RESET_N;
    logic        MEM_V;
    logic [31:0] MEM_IR;
    logic [16:0] MEM_Cst;
    logic [63:0] MEM_RES;
    logic [63:0] MEM_Address;
    logic [63:0] MEM_NPC;
    logic        MEM_PC_MUX;
    logic [63:0] MEM_Target_Address;
    logic        DMEM_REQ;
    logic        DMEM_WE;
    logic [63:0] DMEM_ADDR;
    logic [63:0] DMEM_WDATA;
    logic [7:0]  DMEM_BE;
    logic        DMEM_ACK;
    logic [63:0] DMEM_RDATA;
    logic        MEM_STALL;
    logic        MEM_FE_BR_TAKEN;
    logic [63:0] MEM_FE_TARGET;
    logic [4:0]  MEM_DR;
    logic        WB_V;
    logic [63:0] WB_RES;
    logic [31:0] WB_IR;
    logic [16:0] WB_Cst;
    logic [63:0] WB_NPC;
    logic        WB_EXC;

    int n_tests = 0;
    int n_fail  = 0;

    mem_stage #(.DMEM_TIMEOUT(4)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .MEM_V(MEM_V), .MEM_IR(MEM_IR), .MEM_Cst(MEM_Cst),
        .MEM_RES(MEM_RES), .MEM_Address(MEM_Address), .MEM_NPC(MEM_NPC),
        .MEM_PC_MUX(MEM_PC_MUX), .MEM_Target_Address(MEM_Target_Address),
        .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
        .DMEM_WDATA(DMEM_WDATA), .DMEM_BE(DMEM_BE), .DMEM_ACK(DMEM_ACK),
        .DMEM_RDATA(DMEM_RDATA), .MEM_STALL(MEM_STALL), .MEM_FE_BR_TAKEN(MEM_FE_BR_TAKEN),
        .MEM_FE_TARGET(MEM_FE_TARGET), .MEM_DR(MEM_DR), .WB_V(WB_V), .WB_RES(WB_RES),
        .WB_IR(WB_IR), .WB_Cst(WB_Cst), .WB_NPC(WB_NPC), .WB_EXC(WB_EXC)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: byte-lane view of the access.
    function automatic int m_nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [7:0] m_be(input logic [2:0] f3, input int off);
        logic [7:0] be = '0;
        for (int i = 0; i < m_nbytes(f3); i++)
            if (off + i < 8) be[off + i] = 1'b1;
        return be;
    endfunction

    function automatic logic [63:0] m_wdata(input logic [63:0] d, input int off);
        logic [63:0] w = '0;
        for (int i = 0; i + off < 8; i++) w[8*(i+off) +: 8] = d[8*i +: 8];
        return w;
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] rd, input logic [2:0] f3, input int off);
        logic [63:0] v = '0;
        int n = m_nbytes(f3);
        for (int j = 0; j < n; j++)
            if (off + j < 8) v[8*j +: 8] = rd[8*(off+j) +: 8];
        if (!f3[2] && n < 8 && v[8*n-1])
            for (int k = 8*n; k < 64; k++) v[k] = 1'b1;
        return v;
    endfunction

    function automatic bit m_trap(input bit is_mem, input logic [2:0] f3, input int off);
`ifdef MISALIGN_TRAP_EN
        return is_mem && ((off % m_nbytes(f3)) != 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic run_op(input logic [4:0] opc, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] res, input logic [63:0] rdata, input int dly,
                          input string tag);
        logic [31:0] ir;
        logic [16:0] cst;
        logic [63:0] npc, tgt, exp_res;
        bit is_mem, is_load, trap;
        int off, stall_n;
        ir = $urandom;
        ir[6:0] = {opc, 2'b11};
        ir[14:12] = f3;
        cst = 17'($urandom);
        npc = {$urandom, $urandom};
        tgt = {$urandom, $urandom};
        off = int'(addr[2:0]);
        is_load = (opc == 5'b00000);
        is_mem = is_load || (opc == 5'b01000);
        trap = m_trap(is_mem, f3, off);
        @(negedge CLK);
        MEM_V = 1'b1; MEM_IR = ir; MEM_Cst = cst; MEM_RES = res; MEM_Address = addr;
        MEM_NPC = npc; MEM_PC_MUX = 1'($urandom); MEM_Target_Address = tgt; DMEM_ACK = 1'b0;
        #1;
        n_tests++;
        if (MEM_FE_BR_TAKEN !== MEM_PC_MUX || MEM_FE_TARGET !== tgt || MEM_DR !== ir[11:7]) begin
            n_fail++;
            $display("FAIL %s fwd: got br=%b tgt=%h dr=%h exp br=%b tgt=%h dr=%h", tag,
                     MEM_FE_BR_TAKEN, MEM_FE_TARGET, MEM_DR, MEM_PC_MUX, tgt, ir[11:7]);
        end
        if (!is_mem || trap) begin
            n_tests++;
            if (MEM_STALL !== 1'b0) begin
                n_fail++; $display("FAIL %s stall: got %b exp 0", tag, MEM_STALL);
            end
            exp_res = trap ? addr : res;
        end else begin
            n_tests++;
            if (MEM_STALL !== 1'b1) begin
                n_fail++; $display("FAIL %s stall_idle: got %b exp 1", tag, MEM_STALL);
            end
            stall_n = 1;
            @(negedge CLK);
            n_tests++;
            if (DMEM_REQ !== 1'b1 || DMEM_WE !== !is_load || DMEM_ADDR !== {addr[63:3], 3'b000} ||
                DMEM_BE !== m_be(f3, off) || DMEM_WDATA !== (is_load ? 64'd0 : m_wdata(res, off)) ||
                WB_V !== 1'b0) begin
                n_fail++;
                $display("FAIL %s req: got req=%b we=%b addr=%h be=%h wd=%h wbv=%b exp req=1 we=%b addr=%h be=%h wd=%h wbv=0",
                         tag, DMEM_REQ, DMEM_WE, DMEM_ADDR, DMEM_BE, DMEM_WDATA, WB_V, !is_load,
                         {addr[63:3], 3'b000}, m_be(f3, off), is_load ? 64'd0 : m_wdata(res, off));
            end
            for (int k = 0; k < dly; k++) begin
                if (MEM_STALL) stall_n++;
                @(negedge CLK);
                n_tests++;
                if (DMEM_REQ !== 1'b1 || DMEM_BE !== m_be(f3, off)) begin
                    n_fail++;
                    $display("FAIL %s hold: got req=%b be=%h exp req=1 be=%h", tag, DMEM_REQ, DMEM_BE, m_be(f3, off));
                end
            end
            DMEM_ACK = 1'b1; DMEM_RDATA = rdata;
            #1;
            n_tests++;
            if (MEM_STALL !== 1'b0) begin
                n_fail++; $display("FAIL %s stall_ack: got %b exp 0", tag, MEM_STALL);
            end
            n_tests++;
            if (stall_n !== dly + 1) begin
                n_fail++; $display("FAIL %s stall_cycles: got %0d exp %0d", tag, stall_n, dly + 1);
            end
            exp_res = is_load ? m_load(rdata, f3, off) : res;
        end
        @(negedge CLK);
        DMEM_ACK = 1'b0; DMEM_RDATA = {$urandom, $urandom};
        n_tests++;
        if (WB_V !== 1'b1 || WB_RES !== exp_res || WB_EXC !== trap || DMEM_REQ !== 1'b0 ||
            WB_IR !== ir || WB_Cst !== cst || WB_NPC !== npc) begin
            n_fail++;
            $display("FAIL %s wb: got v=%b res=%h exc=%b req=%b ir=%h exp v=1 res=%h exc=%b req=0 ir=%h",
                     tag, WB_V, WB_RES, WB_EXC, DMEM_REQ, WB_IR, exp_res, trap, ir);
        end
        MEM_V = 1'b0;
        @(negedge CLK);
        n_tests++;
        if (WB_V !== 1'b0 || DMEM_REQ !== 1'b0) begin
            n_fail++; $display("FAIL %s pulse: got v=%b req=%b exp v=0 req=0", tag, WB_V, DMEM_REQ);
        end
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; MEM_V = 1'b0; MEM_IR = '0; MEM_Cst = '0; MEM_RES = '0; MEM_Address = '0;
        MEM_NPC = '0; MEM_PC_MUX = 1'b0; MEM_Target_Address = '0; DMEM_ACK = 1'b0; DMEM_RDATA = '0;
        repeat (3) @(negedge CLK);
        n_tests++;
        if (DMEM_REQ !== 0 || DMEM_WE !== 0 || DMEM_BE !== 0 || DMEM_ADDR !== 0 || DMEM_WDATA !== 0) begin
            n_fail++; $display("FAIL reset_dmem: got req=%b we=%b be=%h addr=%h wd=%h exp all 0",
                               DMEM_REQ, DMEM_WE, DMEM_BE, DMEM_ADDR, DMEM_WDATA);
        end
        n_tests++;
        if (WB_V !== 0 || WB_EXC !== 0 || WB_RES !== 0 || WB_IR !== 0 || WB_Cst !== 0 || WB_NPC !== 0) begin
            n_fail++; $display("FAIL reset_wb: got v=%b exc=%b res=%h ir=%h exp all 0", WB_V, WB_EXC, WB_RES, WB_IR);
        end
        n_tests++;
        if (MEM_STALL !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: got %b exp 0", MEM_STALL);
        end
        RESET_N = 1'b1;
    endtask

    task automatic test_alu();
        run_op(5'b01100, 3'b000, 64'h40, 64'h1234, 64'd0, 0, "add");
        run_op(5'b00100, 3'b011, 64'h5, {$urandom, $urandom}, 64'd0, 0, "addi");
    endtask

    task automatic test_load_lanes();
        run_op(5'b00000, 3'b000, 64'h1003, 64'd0, 64'h00000000_80000000, 0, "lb");
        run_op(5'b00000, 3'b100, 64'h1003, 64'd0, 64'h00000000_80000000, 0, "lbu");
        n_tests++;
        if (WB_RES !== 64'h80) begin
            n_fail++; $display("FAIL lbu_value: got %h exp %h", WB_RES, 64'h80);
        end
    endtask

    task automatic test_store_delay();
        run_op(5'b01000, 3'b001, 64'h2006, 64'hBEEF, 64'd0, 3, "sh");
        n_tests++;
        if (DMEM_WDATA !== 64'hBEEF0000_00000000 || DMEM_BE !== 8'hC0) begin
            n_fail++; $display("FAIL sh_lanes: got wd=%h be=%h exp wd=%h be=c0", DMEM_WDATA, DMEM_BE, 64'hBEEF0000_00000000);
        end
    endtask

    task automatic test_timeout();
        @(negedge CLK);
        MEM_V = 1'b1; MEM_IR = 32'h0000_3003; MEM_Address = 64'h4000; MEM_RES = 64'h77;
        @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (DMEM_REQ !== 1'b1 || MEM_STALL !== 1'b1) begin
                n_fail++; $display("FAIL timeout_wait%0d: got req=%b stall=%b exp 1 1", i, DMEM_REQ, MEM_STALL);
            end
            @(negedge CLK);
        end
        n_tests++;
        if (DMEM_REQ !== 1'b0 || WB_V !== 1'b1 || WB_EXC !== 1'b1 || WB_RES !== 64'd0) begin
            n_fail++; $display("FAIL timeout_wb: got req=%b v=%b exc=%b res=%h exp 0 1 1 0", DMEM_REQ, WB_V, WB_EXC, WB_RES);
        end
        MEM_V = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset_mid();
        @(negedge CLK);
        MEM_V = 1'b1; MEM_IR = 32'h0000_2023; MEM_Address = 64'h5000; MEM_RES = 64'hAB;
        @(negedge CLK);
        n_tests++;
        if (DMEM_REQ !== 1'b1) begin
            n_fail++; $display("FAIL rmid_req: got %b exp 1", DMEM_REQ);
        end
        @(negedge CLK);
        #2 RESET_N = 1'b0;
        #1;
        n_tests++;
        if (DMEM_REQ !== 0 || DMEM_WE !== 0 || WB_V !== 0 || WB_EXC !== 0) begin
            n_fail++; $display("FAIL rmid_async: got req=%b we=%b v=%b exc=%b exp all 0", DMEM_REQ, DMEM_WE, WB_V, WB_EXC);
        end
        @(negedge CLK);
        RESET_N = 1'b1; MEM_V = 1'b0;
        @(negedge CLK);
        DMEM_ACK = 1'b1;
        @(negedge CLK);
        DMEM_ACK = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (WB_V !== 1'b0 || DMEM_REQ !== 1'b0) begin
                n_fail++; $display("FAIL rmid_lateack%0d: got v=%b req=%b exp 0 0", i, WB_V, DMEM_REQ);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_misalign();
        run_op(5'b00000, 3'b010, 64'h3002, 64'd0, {$urandom, $urandom}, 1, "lw_mis");
        run_op(5'b01000, 3'b011, 64'h3005, {$urandom, $urandom}, 64'd0, 0, "sd_mis");
    endtask

    task automatic test_random();
        logic [4:0] opc;
        logic [2:0] f3;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(2))
                0: begin opc = 5'b00000; f3 = 3'($urandom_range(6)); end
                1: begin opc = 5'b01000; f3 = 3'($urandom_range(3)); end
                default: begin opc = 5'b01100; f3 = 3'($urandom); end
            endcase
            run_op(opc, f3, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                   $urandom_range(3), "rand");
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_lanes();
        test_store_delay();
        test_timeout();
        test_reset_mid();
        test_misalign();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
